// File: rtl/axis_s16_pair_packer.sv
// Packs pairs of 16-bit real samples into 32-bit AXI-Stream words, pads odd-length
// packets in the final word, and reports each packet's real-sample count.
module axis_s16_pair_packer #(
  parameter logic [15:0] PAD_VALUE  = 16'h0000,
  parameter bit          HIGH_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_pad,
  output logic [15:0] pkt_samples,
  output logic        pkt_stb
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_hold;
  logic [15:0] r_count;
  logic [15:0] r_pkt_samples;
  logic        r_pkt_stb;
  logic [31:0] r_o_tdata;
  logic        r_o_tlast;
  logic        r_o_tvalid;
  logic        r_o_pad;

  logic        w_free;
  logic        w_accept;
  logic        w_load;
  logic [15:0] w_first;
  logic [15:0] w_second;
  logic [31:0] w_word;
  logic [15:0] w_count_inc;

  // The single output stage can take a new word when empty or being drained.
  assign w_free   = ~r_o_tvalid | o_tready;
  assign i_tready = w_free;
  assign w_accept = i_tvalid & w_free & ~clear;
  assign w_load   = w_accept & ((r_state == ST_HALF) | i_tlast);

  always_comb begin
    w_first  = i_tdata;
    w_second = PAD_VALUE;
    if (r_state == ST_HALF) begin
      w_first  = r_hold;
      w_second = i_tdata;
    end
    w_word = HIGH_FIRST ? {w_first, w_second} : {w_second, w_first};
  end

  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else if (clear) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      if (r_state == ST_HALF) begin
        r_state <= ST_EMPTY;
      end else if (!i_tlast) begin
        r_state <= ST_HALF;
      end
    end
  end

  // NOTE: the held sample is only read in HALF, so clear leaves its contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= 16'h0000;
    end else if (w_accept && (r_state == ST_EMPTY)) begin
      r_hold <= i_tdata;
    end
  end

  // Data/last/pad only change on a load, and a load needs a free stage, so they hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_o_tvalid <= 1'b0;
      r_o_tdata  <= 32'h0000_0000;
      r_o_tlast  <= 1'b0;
      r_o_pad    <= 1'b0;
    end else if (clear) begin
      r_o_tvalid <= 1'b0;
    end else if (w_load) begin
      r_o_tvalid <= 1'b1;
      r_o_tdata  <= w_word;
      r_o_tlast  <= i_tlast;
      r_o_pad    <= (r_state == ST_EMPTY);
    end else if (o_tready) begin
      r_o_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= 16'h0000;
      r_pkt_samples <= 16'h0000;
      r_pkt_stb     <= 1'b0;
    end else if (clear) begin
      r_count   <= 16'h0000;
      r_pkt_stb <= 1'b0;
    end else begin
      r_pkt_stb <= 1'b0;
      if (w_accept) begin
        if (i_tlast) begin
          r_pkt_samples <= w_count_inc;
          r_pkt_stb     <= 1'b1;
          r_count       <= 16'h0000;
        end else begin
          r_count <= w_count_inc;
        end
      end
    end
  end

  assign o_tdata     = r_o_tdata;
  assign o_tlast     = r_o_tlast;
  assign o_tvalid    = r_o_tvalid;
  assign o_pad       = r_o_pad;
  assign pkt_samples = r_pkt_samples;
  assign pkt_stb     = r_pkt_stb;

endmodule
